// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake bundle for the UART transmitter.
interface uart_tx_if;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;

  // Producer side: supplies bytes and the bit-rate strobe, watches the line.
  modport master (
    output baud_tick,
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx,
    input  busy,
    input  frame_done
  );

  // Transmitter side.
  modport slave (
    input  baud_tick,
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding register feeding a start/data/parity/stop
// frame shifter. All state advances only on baud_tick edges; outputs are flops.
module uart_tx #(
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input logic     clk,
  input logic     reset,
  uart_tx_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic StopLast = 1'(STOP_BITS - 1);

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       parity_q, parity_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic       load;

  // Next-state: byte acceptance, frame sequencing and hold-to-shifter transfer.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    parity_d     = parity_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;
    load         = 1'b0;

    // A full holding register ignores tx_valid, so accept and load never coincide.
    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    if (bus.baud_tick) begin
      unique case (state_q)
        StIdle: begin
          if (hold_full_q) load = 1'b1;
        end
        StStart: begin
          state_d   = StData;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = 3'd0;
        end
        StData: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = StParity;
              tx_d    = parity_q;
            end else begin
              state_d    = StStop;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
        StParity: begin
          state_d    = StStop;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
        StStop: begin
          if (stop_cnt_q == StopLast) begin
            frame_done_d = 1'b1;
            // A waiting byte starts immediately, with no idle bit in between.
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          tx_d    = 1'b1;
        end
      endcase
    end

    // Parity is captured with the byte since the shifter is consumed bit by bit.
    if (load) begin
      state_d     = StStart;
      tx_d        = 1'b0;
      shift_d     = hold_q;
      parity_d    = (^hold_q) ^ PARITY_ODD;
      hold_full_d = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  // State and output registers, asynchronously cleared to an idle-high line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      hold_q       <= 8'h00;
      hold_full_q  <= 1'b0;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      stop_cnt_q   <= 1'b0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.tx_ready   = ~hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations (plain, 2 stop bits, even parity,
// odd parity) checked against a bit-list frame model sampled every clock.
module tb_uart_tx;

  localparam logic [3:0] PE_CFG    = 4'b1100;
  localparam logic [3:0] ODD_CFG   = 4'b1000;
  localparam logic [3:0] STOP2_CFG = 4'b0010;
  localparam int         TICK_DIV  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       tick_en = 1'b1;
  int         tick_cnt = 0;
  logic [7:0] data_r [4];
  logic [3:0] valid_r = 4'b0000;
  logic [3:0] tx_w, busy_w, ready_w, done_w;

  int errs = 0;
  int checks = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_if bus ();
    assign bus.baud_tick = tick;
    assign bus.tx_data   = data_r[g];
    assign bus.tx_valid  = valid_r[g];
    assign tx_w[g]       = bus.tx;
    assign busy_w[g]     = bus.busy;
    assign ready_w[g]    = bus.tx_ready;
    assign done_w[g]     = bus.frame_done;

    uart_tx #(
      .PARITY_EN (PE_CFG[g]),
      .PARITY_ODD(ODD_CFG[g]),
      .STOP_BITS (STOP2_CFG[g] ? 2 : 1)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  // One-clock tick every TICK_DIV clocks, changed on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      tick_cnt = (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
      tick = tick_en && (tick_cnt == 0);
    end
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s u%0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Expected line levels, one entry per bit period.
  task automatic push_frame(input int k, input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    if (PE_CFG[k]) exp_q.push_back((^b) ^ ODD_CFG[k]);
    for (int i = 0; i < (STOP2_CFG[k] ? 2 : 1); i++) exp_q.push_back(1'b1);
  endtask

  // Called on a falling edge; valid is high for exactly one rising edge.
  task automatic write_byte(input int k, input logic [7:0] b);
    data_r[k]  = b;
    valid_r[k] = 1'b1;
    @(negedge clk);
    valid_r[k] = 1'b0;
  endtask

  // Waits for the start bit; returns number of falling edges waited or -1.
  task automatic wait_start(input int k, output int cnt);
    cnt = 0;
    while (tx_w[k] !== 1'b0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    if (tx_w[k] !== 1'b0) begin
      chk("start_timeout", k, {31'd0, tx_w[k]}, 32'd0);
      cnt = -1;
    end
  endtask

  task automatic check_frames(input int k, input logic [7:0] b0, input bit two,
                              input logic [7:0] b1, input bit do_write);
    int cnt, len0, tot;
    exp_q.delete();
    push_frame(k, b0);
    len0 = exp_q.size() * TICK_DIV;
    if (two) push_frame(k, b1);
    tot = exp_q.size() * TICK_DIV;
    if (do_write) write_byte(k, b0);
    wait_start(k, cnt);
    if (cnt < 0) return;
    if (do_write) chk("latency", k, {31'd0, cnt <= TICK_DIV}, 32'd1);
    for (int n = 0; n <= tot; n++) begin
      if (n > 0) @(negedge clk);
      if (n < tot) begin
        chk("tx_bit", k, {31'd0, tx_w[k]}, {31'd0, exp_q[n / TICK_DIV]});
        chk("busy", k, {31'd0, busy_w[k]}, 32'd1);
        chk("frame_done", k, {31'd0, done_w[k]},
            {31'd0, (two && n == len0)});
      end else begin
        chk("end_tx", k, {31'd0, tx_w[k]}, 32'd1);
        chk("end_busy", k, {31'd0, busy_w[k]}, 32'd0);
        chk("end_done", k, {31'd0, done_w[k]}, 32'd1);
      end
      if (n == 1) chk("ready_after_load", k, {31'd0, ready_w[k]}, 32'd1);
      if (two) begin
        if (n == 3) chk("ready_held", k, {31'd0, ready_w[k]}, 32'd0);
        if (n == len0 - 1) chk("ready_before_xfer", k, {31'd0, ready_w[k]}, 32'd0);
        if (n == len0) chk("ready_after_xfer", k, {31'd0, ready_w[k]}, 32'd1);
        if (n == 2) begin
          data_r[k]  = b1;
          valid_r[k] = 1'b1;
        end
        if (n == 3) valid_r[k] = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_pulse_end", k, {31'd0, done_w[k]}, 32'd0);
  endtask

  initial begin
    int cnt;
    logic [7:0] a, b;
    for (int k = 0; k < 4; k++) data_r[k] = 8'h00;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_tx", k, {31'd0, tx_w[k]}, 32'd1);
      chk("rst_busy", k, {31'd0, busy_w[k]}, 32'd0);
      chk("rst_ready", k, {31'd0, ready_w[k]}, 32'd1);
      chk("rst_done", k, {31'd0, done_w[k]}, 32'd0);
    end
    reset = 1'b0;

    // No frame without a written byte, even with ticks running.
    repeat (40) @(negedge clk);
    chk("idle_tx", 0, {31'd0, tx_w[0]}, 32'd1);
    chk("idle_busy", 0, {31'd0, busy_w[0]}, 32'd0);

    check_frames(0, 8'hA5, 1'b0, 8'h00, 1'b1);
    check_frames(1, 8'h3C, 1'b0, 8'h00, 1'b1);
    check_frames(2, 8'h07, 1'b0, 8'h00, 1'b1);
    check_frames(3, 8'h07, 1'b0, 8'h00, 1'b1);
    check_frames(0, 8'h00, 1'b1, 8'hFF, 1'b1);

    for (int k = 0; k < 4; k++) begin
      repeat (3) begin
        a = 8'($urandom);
        repeat ($urandom_range(0, 20)) @(negedge clk);
        check_frames(k, a, 1'b0, 8'h00, 1'b1);
      end
      a = 8'($urandom);
      b = 8'($urandom);
      check_frames(k, a, 1'b1, b, 1'b1);
    end

    // Reset during data bit 4 with a second byte held.
    write_byte(0, 8'h96);
    wait_start(0, cnt);
    if (cnt >= 0) begin
      for (int n = 0; n < 5 * TICK_DIV + 5; n++) begin
        if (n == 2) begin
          data_r[0]  = 8'h5A;
          valid_r[0] = 1'b1;
        end
        if (n == 3) valid_r[0] = 1'b0;
        @(negedge clk);
      end
      chk("pre_rst_ready", 0, {31'd0, ready_w[0]}, 32'd0);
      reset = 1'b1;
      #1;
      chk("midrst_tx", 0, {31'd0, tx_w[0]}, 32'd1);
      chk("midrst_busy", 0, {31'd0, busy_w[0]}, 32'd0);
      chk("midrst_ready", 0, {31'd0, ready_w[0]}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
        repeat (8) @(negedge clk);
        chk("post_rst_tx", 0, {31'd0, tx_w[0]}, 32'd1);
        chk("post_rst_busy", 0, {31'd0, busy_w[0]}, 32'd0);
      end
    end

    // tx_valid stuck high with no ticks: only the first byte is taken.
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'($urandom);
    b = a ^ 8'h5A;
    data_r[0]  = a;
    valid_r[0] = 1'b1;
    @(negedge clk);
    data_r[0] = b;
    for (int i = 0; i < 5; i++) begin
      repeat (6) @(negedge clk);
      chk("stuck_ready", 0, {31'd0, ready_w[0]}, 32'd0);
      chk("stuck_tx", 0, {31'd0, tx_w[0]}, 32'd1);
      chk("stuck_busy", 0, {31'd0, busy_w[0]}, 32'd0);
    end
    valid_r[0] = 1'b0;
    tick_en = 1'b1;
    check_frames(0, a, 1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-002 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-003 SHALL have parameter STOP_BITS, default 1: number of stop bits, legal values 1 or 2.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port baud_tick  input  1  one-clk pulse per bit period, from the baud timer stage.
REQ-007 SHALL have port tx_data  input  8  byte to transmit.
REQ-008 SHALL have port tx_valid  input  1  tx_data is valid this cycle.
REQ-009 SHALL have port tx_ready  output  1  holding register empty, byte can be accepted.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port frame_done  output  1  one-clk pulse at end of frame.

Function
REQ-013 SHALL hold one byte in a holding register; tx_ready = NOT hold_full.
REQ-014 SHALL accept tx_data on a rising edge where tx_valid=1 and tx_ready=1; hold_full sets on that edge.
REQ-015 SHALL ignore tx_valid while tx_ready=0; no overwrite, no error flag.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP; busy=1 in every state except IDLE.
REQ-017 IDLE: SHALL leave only on an edge with baud_tick=1 and hold_full=1.
REQ-018 IDLE exit: SHALL move the holding register to the shifter, clear hold_full, enter START and drive tx=0 on that edge.
REQ-019 Bit timing: each bit SHALL last exactly one tick period; state and tx SHALL change only on edges with baud_tick=1.
REQ-020 START -> DATA on the next tick; DATA SHALL send 8 bits LSB first; a 3-bit counter SHALL wrap 7->0 on the last bit.
REQ-021 After bit 7: SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-022 Parity bit: SHALL be XOR of the 8 data bits for even parity, inverted for odd parity.
REQ-023 STOP: SHALL hold tx=1 for STOP_BITS tick periods.
REQ-024 On the tick ending the last stop bit: SHALL assert frame_done=1 for exactly the following clk cycle.
REQ-025 Same tick as REQ-024 with hold_full=1: SHALL go directly to START (tx=0) with no idle bit; with hold_full=0, SHALL go to IDLE.
REQ-026 Acceptance and hold-to-shifter transfer on the same edge cannot coincide, because tx_ready=0 on that edge; tx_ready SHALL rise the cycle after the transfer.
REQ-027 A byte accepted on an IDLE edge that also carries baud_tick SHALL wait for the next tick to start.
REQ-028 Latency from acceptance to start bit SHALL be at most one tick period plus one clk when idle.
REQ-029 All outputs SHALL be registered; tx SHALL be glitch-free.

Reset
REQ-030 reset=1 SHALL asynchronously force: state=IDLE, tx=1, busy=0, tx_ready=1 (hold_full=0), frame_done=0, shifter=0, bit counter=0.
REQ-031 Reset mid-frame SHALL abort the frame and discard any held byte; the line SHALL return high immediately.
REQ-032 After reset deasserts, no frame SHALL start until a byte is accepted and a tick occurs.

Verification
REQ-033 0xA5, PARITY_EN=0, tick every 16 clk -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 16 clk; one frame_done pulse; busy drops afterwards.
REQ-034 0x00 accepted, then 0xFF accepted while busy -> tx_ready low until 0xFF moves to the shifter; after the stop bit the 0xFF start bit follows on the next tick with no idle gap; two frame_done pulses.
REQ-035 PARITY_EN=1, 0x07 -> parity bit 1 with PARITY_ODD=0, 0 with PARITY_ODD=1; frame is 11 bits.
REQ-036 STOP_BITS=2, 0x3C -> tx high for 2 tick periods after bit 7; frame_done only after the second.
REQ-037 Assert reset during bit 4 of a frame with a byte held -> tx=1, busy=0, tx_ready=1 in the same cycle; no further frame without a new write.
REQ-038 tx_valid held high with baud_tick tied 0 -> exactly one byte accepted, tx stays 1, busy stays 0.
